// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// valid/ack holding register with sticky framing and overrun flags.
module uart_rx_8n1 #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, rxs_q;
  logic             done, stop_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    done     = 1'b0;
    stop_bad = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint is a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shreg_d[idx_q] = rxs_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          done     = 1'b1;
          stop_bad = !rxs_q;
          state_d  = rxs_q ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion takes priority over ack and err_clr so a new byte or error is never lost.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (rx_ack) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (done) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (stop_bad) begin
        ferr_d = 1'b1;
      end
      if (valid_q && !rx_ack) begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: directed frames plus randomized frames
// compared against a transaction-level model of the holding register and flags.
module tb_uart_rx_8n1;

  localparam int unsigned BD  = 4;
  localparam int unsigned LAT = 2 + BD / 2 + 9 * BD;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  uart_rx_8n1 #(
    .BAUD_DIV(BD),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Effect of one completed frame on the consumer-visible state.
  task automatic model_done(input logic [7:0] b, input logic stop, input logic ack, input logic clr);
    if (clr) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (m_valid && !ack) m_ovr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"},  32'(rx_data),   32'(m_data));
    check({tag, "_valid"}, 32'(rx_valid),  32'(m_valid));
    check({tag, "_ferr"},  32'(frame_err), 32'(m_ferr));
    check({tag, "_ovr"},   32'(overrun),   32'(m_ovr));
  endtask

  // Drives start, 8 data bits and the stop level; returns just after the
  // last edge before the completion edge, leaving rxd at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BD) tick();
    end
    rxd = stop;
    repeat (BD) tick();
  endtask

  task automatic complete(input logic [7:0] b, input logic stop, input logic ack, input logic clr);
    rx_ack  = ack;
    err_clr = clr;
    tick();
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    model_done(b, stop, ack, clr);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] b;
    logic       stop, ack, clr;
    int         rise;

    reset   = 1'b1;
    rxd     = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) tick();
    check_all("reset");
    check("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    repeat (3) tick();

    // Exact latency from the falling edge of the start bit.
    fr   = {1'b1, 8'hA5, 1'b0};
    rise = -1;
    for (int c = 0; c < int'(LAT) + 4 && rise < 0; c++) begin
      rxd = (c < int'(10 * BD)) ? fr[c / int'(BD)] : 1'b1;
      tick();
      if (rx_valid) rise = c;
    end
    rxd = 1'b1;
    check("a5_latency", 32'(rise), 32'(LAT));
    model_done(8'hA5, 1'b1, 1'b0, 1'b0);
    check_all("a5");
    pulse_ack();
    check("a5_ack_valid", 32'(rx_valid), 32'(0));
    tick();

    // Overrun: unacked 0x3C overwritten by 0xC3.
    send_frame(8'h3C, 1'b1);
    complete(8'h3C, 1'b1, 1'b0, 1'b0);
    check_all("3c");
    repeat (2) tick();
    send_frame(8'hC3, 1'b1);
    complete(8'hC3, 1'b1, 1'b0, 1'b0);
    check_all("c3_ovr");
    pulse_clr();
    check_all("c3_clr");
    pulse_ack();
    tick();

    // Framing error followed by a held-low line.
    send_frame(8'h55, 1'b0);
    complete(8'h55, 1'b0, 1'b0, 1'b0);
    check_all("55_ferr");
    pulse_ack();
    repeat (6) tick();
    check("break_busy", 32'(busy), 32'(1));
    check("break_valid", 32'(rx_valid), 32'(0));
    rxd = 1'b1;
    repeat (4) tick();
    check("break_idle", 32'(busy), 32'(0));
    check_all("break_end");
    pulse_clr();
    tick();

    // One-cycle glitch must not start a frame.
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (2) tick();
    check("glitch_start_busy", 32'(busy), 32'(1));
    repeat (2) tick();
    check("glitch_mid_busy", 32'(busy), 32'(0));
    check("glitch_mid_valid", 32'(rx_valid), 32'(0));
    check("glitch_mid_ferr", 32'(frame_err), 32'(0));
    repeat (40) tick();
    check_all("glitch_end");
    check("glitch_end_busy", 32'(busy), 32'(0));

    // Reset in the middle of data bit 4 discards the partial byte.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (22) tick();
        check("rst_mid_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        check_all("rst_mid");
      end
    join
    check("rst_after_busy", 32'(busy), 32'(0));
    check_all("rst_after");
    repeat (2) tick();
    send_frame(8'h81, 1'b1);
    complete(8'h81, 1'b1, 1'b0, 1'b0);
    check_all("81");
    pulse_ack();
    tick();

    // Back-to-back frames, ack on the second completion edge.
    send_frame(8'h01, 1'b1);
    fork
      send_frame(8'h80, 1'b1);
      begin
        tick();
        model_done(8'h01, 1'b1, 1'b0, 1'b0);
        check_all("b2b_01");
      end
    join
    complete(8'h80, 1'b1, 1'b1, 1'b0);
    check_all("b2b_80");
    pulse_ack();
    tick();

    // Randomized frames, acks and clears.
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      stop = ($urandom % 4) != 0;
      ack  = 1'($urandom % 2);
      clr  = ($urandom % 4) == 0;
      repeat ($urandom % 3) tick();
      send_frame(b, stop);
      complete(b, stop, ack, clr);
      check_all("rnd");
      if (!stop) begin
        repeat ($urandom_range(0, 5)) tick();
        check("rnd_wait_busy", 32'(busy), 32'(1));
        rxd = 1'b1;
        repeat (3) tick();
        check("rnd_idle_busy", 32'(busy), 32'(0));
      end
      if ($urandom % 2 == 1) begin
        pulse_ack();
        check_all("rnd_ack");
      end
      if ($urandom % 4 == 0) begin
        pulse_clr();
        check_all("rnd_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Serial receiver for the CPU's UART peripheral: 8 data bits, no parity, 1 stop bit, LSB first; line idles high.
- Converts the rxd line into bytes presented to the bridge/device-register side through a valid/ack holding register.
- Pairs with the transmit side of the same link; bit timing is set by a clock-count divider.
- Error flags: framing errors and overruns.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idle = 1.
- rx_data  output  8  last received byte, held stable while rx_valid=1.
- rx_valid  output  1  holding register contains an unread byte.
- rx_ack  input  1  consumer pulse; clears rx_valid on the same posedge.
- frame_err  output  1  sticky; set when a stop bit samples 0.
- overrun  output  1  sticky; set when a byte completes while rx_valid=1.
- err_clr  input  1  clears frame_err and overrun.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values (reset sampled high at posedge):
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, counters=0, synchroniser flops=1.
  - Reset overrides every other input, including a reset asserted mid-frame; the partial byte is discarded.
- Synchroniser: rxd passes through 2 flops; rxs is the second flop. All decisions use rxs, giving 2 cycles of input latency.
- IDLE: when rxs==0, go to START, load cnt=0, busy=1.
- START:
  - cnt increments each cycle.
  - At cnt==BAUD_DIV/2-1 (integer division), re-check rxs.
  - If rxs==0, go to DATA with cnt=0, bit index=0.
  - If rxs==1, treat as a glitch and return to IDLE; no flags change.
- DATA:
  - cnt counts 0..BAUD_DIV-1.
  - At cnt==BAUD_DIV-1, shift rxs into shreg bit [index], index++, cnt=0.
  - After index 7 is sampled, go to STOP.
- STOP: at cnt==BAUD_DIV-1, sample rxs, then:
  - rx_data<=shreg.
  - rx_valid<=1 (always, even on a framing error; the data is still delivered).
  - If rxs==0, frame_err<=1.
  - If rx_valid was already 1 and rx_ack is not asserted that same cycle, overrun<=1. The old byte is overwritten by the new one.
  - Next state: IDLE if rxs==1. If rxs==0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a held-low line (break) from being re-read as endless 0x00 bytes.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid at that posedge.
  - rx_ack while rx_valid=0 is ignored.
  - rx_ack in the same cycle as a byte completing: the new byte is loaded, rx_valid stays 1, and no overrun is flagged.
- err_clr clears both sticky flags.
  - If err_clr coincides with a new error event, the set wins.
- Timing: rx_valid rises exactly 2 + BAUD_DIV/2 + 9*BAUD_DIV cycles after rxd falls, measured from the first posedge that captures rxd=0 in sync flop 1. Exact-cycle checking is required with BAUD_DIV=4, i.e. 40 cycles.
- busy=1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- BAUD_DIV=4, reset held 2 cycles then released, send byte 0xA5 (rxd: 0, 1,0,1,0,0,1,0,1, 1) -> rx_data=0xA5 and rx_valid=1 at cycle 40 after rxd falls; frame_err=0; ack next cycle -> rx_valid=0.
- Send 0x3C and leave it unacked, then send 0xC3 -> rx_data=0xC3, rx_valid=1, overrun=1; pulse err_clr -> overrun=0.
- Send 0x55 with stop bit 0, line returns high 8 cycles later -> rx_data=0x55, rx_valid=1, frame_err=1; FSM passes through WAIT_HIGH and only then reaches IDLE; no second byte reported.
- Glitch: rxd low for 1 cycle only -> START aborts to IDLE; rx_valid, frame_err and busy are all 0 by mid-bit; no byte produced.
- Reset asserted during DATA bit 4 of 0xFF, released, then send 0x81 -> only 0x81 is reported; all flags 0.
- Back-to-back 0x01 and 0x80 with zero idle gap, with rx_ack asserted exactly on 0x80's completion cycle -> both bytes received; overrun=0; rx_valid=1 holding 0x80.
